// File: rtl/nd_mem_arbiter_if.sv
// Request/grant and memory-strobe bundle shared by the nd memory arbiter and its requesters.
interface nd_mem_arbiter_if #(
  parameter int unsigned a  = 16,
  parameter int unsigned lw = 16
);

  logic [2:0]      req;
  logic [2:0]      wr;
  logic [3*a-1:0]  base;
  logic [3*lw-1:0] len;
  logic [2:0]      gnt;
  logic            busy;
  logic [a-1:0]    nd_addr;
  logic [7:0]      nd_we;
  logic            e_nd;
  logic            dtb;
  logic            rd_valid;
  logic            rd_last;
  logic [2:0]      done;

  // Requester side: raises requests, observes grant and memory strobes.
  modport master (
    output req, wr, base, len,
    input  gnt, busy, nd_addr, nd_we, e_nd, dtb, rd_valid, rd_last, done
  );

  // Arbiter side: samples requests, drives grant and memory strobes.
  modport slave (
    input  req, wr, base, len,
    output gnt, busy, nd_addr, nd_we, e_nd, dtb, rd_valid, rd_last, done
  );

endinterface

// File: rtl/nd_mem_arbiter.sv
// Round-robin arbiter and burst sequencer for the single-port nd memory.
// One requester at a time gets a non-preemptible burst of consecutive
// addresses; read data is flagged one cycle after each read beat.
module nd_mem_arbiter #(
  parameter int unsigned a  = 16,
  parameter int unsigned lw = 16
) (
  input logic              clk,
  input logic              rst,
  nd_mem_arbiter_if.slave  bus
);

  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        own_q, own_d;
  logic              wr_q, wr_d;
  logic [a-1:0]      addr_q, addr_d;
  logic [lw-1:0]     cnt_q, cnt_d;
  logic [7:0]        we_q, we_d;
  logic              e_nd_q, e_nd_d;
  logic              dtb_q, dtb_d;
  logic              rv_q, rv_d;
  logic              rl_q, rl_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [1:0]        last_q, last_d;
  logic [NREQ-1:0]   mask_q, mask_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   elig;
  logic              found;
  logic [1:0]        win;
  logic [1:0]        probe;
  logic [a-1:0]      sel_base;
  logic [lw-1:0]     sel_len;
  logic              sel_wr;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    elig  = bus.req & ~mask_q;
    found = 1'b0;
    win   = 2'd0;
    probe = 2'd0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      probe = 2'((int'(last_q) + k) % int'(NREQ));
      if (!found && elig[probe]) begin
        found = 1'b1;
        win   = probe;
      end
    end
  end

  // Select the winning requester's burst descriptor.
  always_comb begin
    sel_base = bus.base[0 +: a];
    sel_len  = bus.len[0 +: lw];
    sel_wr   = bus.wr[0];
    case (win)
      2'd1: begin
        sel_base = bus.base[a +: a];
        sel_len  = bus.len[lw +: lw];
        sel_wr   = bus.wr[1];
      end
      2'd2: begin
        sel_base = bus.base[2*a +: a];
        sel_len  = bus.len[2*lw +: lw];
        sel_wr   = bus.wr[2];
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic; strobes are computed one cycle ahead.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = 8'h00;
    e_nd_d  = 1'b0;
    dtb_d   = 1'b0;
    rv_d    = e_nd_q;
    rl_d    = 1'b0;
    done_d  = '0;
    last_d  = last_q;
    mask_d  = mask_q;

    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (found) begin
          own_d = win;
          wr_d  = sel_wr;
          if (sel_len == '0) begin
            state_d = DONE;
            gnt_d   = '0;
            addr_d  = '0;
            done_d  = 3'b001 << win;
          end else begin
            state_d = BURST;
            gnt_d   = 3'b001 << win;
            addr_d  = sel_base;
            cnt_d   = sel_len - lw'(1);
            we_d    = sel_wr ? 8'hFF : 8'h00;
            e_nd_d  = ~sel_wr;
            dtb_d   = sel_wr;
          end
        end
      end
      BURST: begin
        if (cnt_q != '0) begin
          addr_d = addr_q + a'(1);
          cnt_d  = cnt_q - lw'(1);
          we_d   = wr_q ? 8'hFF : 8'h00;
          e_nd_d = ~wr_q;
          dtb_d  = wr_q;
        end else begin
          addr_d = '0;
          rl_d   = ~wr_q;
          if (wr_q) begin
            state_d = DONE;
            gnt_d   = '0;
            done_d  = 3'b001 << own_q;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        gnt_d   = '0;
        done_d  = 3'b001 << own_q;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = own_q;
        mask_d  = 3'b001 << own_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= 2'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 8'h00;
      e_nd_q  <= 1'b0;
      dtb_q   <= 1'b0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
      done_q  <= '0;
      last_q  <= 2'd2;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      e_nd_q  <= e_nd_d;
      dtb_q   <= dtb_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
      done_q  <= done_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.nd_addr  = addr_q;
  assign bus.nd_we    = we_q;
  assign bus.e_nd     = e_nd_q;
  assign bus.dtb      = dtb_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_last  = rl_q;
  assign bus.done     = done_q;

endmodule

// File: doc/nd_mem_arbiter.md
# nd_mem_arbiter

Arbiter and burst sequencer for the single-port node/coefficient memory (nd memory) in the neural-network core. Three requesters share the port: coefficient loader (0), learned-coefficient saver (1), host/debug access (2). The block grants one requester at a time using round-robin. It then drives a non-preemptible burst of consecutive addresses, generating the bus-buffer enables and write strobes, and flags read data one cycle later to absorb BRAM read latency.

## Interface
- `a`, 16: memory address width.
- `lw`, 16: burst-length field width per requester.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in 3: per-requester level request; hold high until its `done` pulse.
- `wr` in 3: per-requester direction, 1 = write burst, 0 = read burst; sampled with `req` at grant.
- `base` in 3*a: packed start addresses, requester r at `[r*a +: a]`.
- `len` in 3*lw: packed burst lengths in words, requester r at `[r*lw +: lw]`.
- `gnt` out 3: one-hot grant, high for the whole burst including the drain cycle.
- `busy` out 1: high whenever the state is not IDLE.
- `nd_addr` out a: memory address.
- `nd_we` out 8: memory byte write enables; 8'hFF on write beats, else 0.
- `e_nd` out 1: memory-to-bus buffer enable; high on read beats.
- `dtb` out 1: 1 = granted requester drives the bus toward memory (write beats), else 0.
- `rd_valid` out 1: bus carries read data for the beat issued the previous cycle.
- `rd_last` out 1: qualifies `rd_valid` for the final word of a read burst.
- `done` out 3: one-cycle completion pulse to the served requester.

## Operation
- States: IDLE, BURST, DRAIN, DONE.
- IDLE:
  - Requesters are eligible when `req` is high and not masked.
  - The winner is the first eligible requester searching from `last+1` mod 3.
  - Latch `gnt`, `wr`, `nd_addr`=base, and a beat counter `cnt`=len−1.
  - If len==0, go to DONE with no memory beat. Otherwise go to BURST.
- BURST: one beat per cycle.
  - Write beat: `nd_we`=8'hFF, `dtb`=1, `e_nd`=0.
  - Read beat: `e_nd`=1, `nd_we`=0, `dtb`=0.
  - When `cnt`≠0: `nd_addr` increments by 1 and `cnt` decrements.
  - When `cnt`==0: the current beat is the last one. Read bursts go to DRAIN; write bursts go to DONE.
- DRAIN (read only): one cycle. All strobes are 0. `rd_valid`=`rd_last`=1.
- DONE:
  - `done[g]`=1 and `gnt`=0; all strobes are 0.
  - Set `last`=g, mask requester g for the next IDLE cycle only, then go to IDLE.
- `rd_valid` is the registered copy of "read beat issued"; `rd_last` is set only with the final word.
- Address arithmetic is modulo 2^a. A burst crossing the top address wraps to 0 without error.
- `req` is sampled only in IDLE. Deasserting `req` mid-burst does not abort the burst, and `base`/`len`/`wr` changes mid-burst are ignored.
- A burst of length L occupies the port for L beats. There is at least one non-beat cycle (DONE) between consecutive bursts.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `gnt`=0, `busy`=0, `nd_addr`=0, `nd_we`=0, `e_nd`=0, `dtb`=0, `rd_valid`=0, `rd_last`=0, `done`=0, `last`=2 (requester 0 has first priority), mask cleared.
  - Reset takes effect the same edge, even mid-burst. No further strobes are issued; the aborted requester receives no `done`.
- With IDLE seeing `req` in cycle c:
  - `gnt` and the first beat (`nd_addr`=base) appear in cycle c+1.
  - Beat i is in cycle c+1+i.
  - Read data for beat i is valid (`rd_valid`) in cycle c+2+i.
- Completion:
  - Write: DONE (`done` pulse) in cycle c+1+L; next arbitration in cycle c+2+L.
  - Read: DRAIN in cycle c+1+L; DONE in cycle c+2+L.
  - len==0: DONE in cycle c+1.
- Simultaneous requests resolve purely by the round-robin pointer. The same requester can never win twice in a row while another is requesting.

## Test plan
- Reset state: hold `rst`=0 with `req`=3'b111 → all outputs 0. On release, requester 0 is granted first.
- Single read: req0 with base=0x0010, len=4, wr=0 → `nd_addr` 0x10..0x13 on 4 consecutive cycles with `e_nd`=1; `rd_valid` on the next 4 cycles, `rd_last` on the 4th; `done[0]` one cycle after the last `rd_valid`.
- Single write: req1 with base=0xFFFE, len=3, wr=1 → addresses 0xFFFE, 0xFFFF, 0x0000 with `nd_we`=8'hFF and `dtb`=1; `done[1]` in the following cycle; `rd_valid` never set.
- Round-robin fairness: all three `req` held high with len=2 → grant order 0,1,2,0,1,2; exactly one DONE cycle gap between bursts; `gnt` always one-hot.
- Zero length and abort: req2 with len=0 → `done[2]` one cycle after grant, no `e_nd`/`nd_we`. Then a read of len=8 with `rst` pulsed low at beat 3 → all outputs 0 next cycle and no `done`.
- Request drop: req0 deasserted at beat 1 of a len=5 write → all 5 beats still issued and `done[0]` still pulses.
